fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32 core, directly upstream of the decode-stage control unit. Owns the PC, issues in-order requests to instruction memory, buffers returned words with their PCs in a small prefetch queue, and drives the IF/ID register (`InstrD`, `PCD`, `PCPlus4D`) that decode consumes combinationally. Handles stall and flush from the hazard unit and redirects from taken branches and jumps resolved in Execute.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction-fetch stage with prefetch queue and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      r_pc;
  logic [31:0]      r_q_pc    [DEPTH];
  logic [31:0]      r_q_instr [DEPTH];
  logic [DEPTH-1:0] r_q_filled;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_pending;
  logic [CW-1:0]    r_drop;

  logic             w_alloc;
  logic             w_fill;
  logic             w_head_filled;
  logic [PW-1:0]    w_fill_idx;
  logic [31:0]      w_target;

  assign ImemReqValid  = !reset && !PCSrcE && (r_count < CW'(DEPTH));
  assign ImemReqAddr   = r_pc;
  assign w_alloc       = ImemReqValid && ImemReqReady;
  // Responses return in order, so the oldest unfilled entry sits r_pending slots behind the tail.
  assign w_fill        = ImemRspValid && (r_drop == '0);
  assign w_fill_idx    = r_tail - r_pending[PW-1:0];
  assign w_head_filled = (r_count != '0) && r_q_filled[r_head];
  assign w_target      = PCTargetE & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_drop     <= '0;
      r_q_filled <= '0;
      ValidD     <= 1'b0;
      InstrD     <= NOP;
      PCD        <= 32'h0;
      PCPlus4D   <= 32'h0;
    end else if (PCSrcE) begin
      // Every still-unfilled entry has a response in flight that must now be discarded.
      r_pc       <= w_target;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_q_filled <= '0;
      r_drop     <= r_drop + r_pending - CW'(ImemRspValid);
      ValidD     <= 1'b0;
      InstrD     <= NOP;
    end else begin
      if (ImemRspValid && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_fill) begin
        r_q_instr[w_fill_idx]  <= ImemRspData;
        r_q_filled[w_fill_idx] <= 1'b1;
      end
      if (w_alloc) begin
        r_q_pc[r_tail]     <= r_pc;
        r_q_filled[r_tail] <= 1'b0;
        r_tail             <= r_tail + PW'(1);
        r_pc               <= r_pc + 32'd4;
      end
      r_pending <= r_pending + CW'(w_alloc) - CW'(w_fill);

      if (FlushD) begin
        ValidD  <= 1'b0;
        InstrD  <= NOP;
        r_count <= r_count + CW'(w_alloc);
      end else if (StallD) begin
        r_count <= r_count + CW'(w_alloc);
      end else if (w_head_filled) begin
        ValidD   <= 1'b1;
        InstrD   <= r_q_instr[r_head];
        PCD      <= r_q_pc[r_head];
        PCPlus4D <= r_q_pc[r_head] + 32'd4;
        r_head   <= r_head + PW'(1);
        r_count  <= r_count + CW'(w_alloc) - CW'(1);
      end else begin
        ValidD  <= 1'b0;
        InstrD  <= NOP;
        r_count <= r_count + CW'(w_alloc);
      end
    end
  end

endmodule
